aes_inv_keygen: RTL and testbench
=================================

# aes_inv_keygen

Sequential AES-128 decryption key scheduler. It takes the cipher key, expands it forward one round per cycle to reach the round-10 key, then walks the schedule backwards. It emits round keys 10, 9, …, 0 over a valid/ready handshake. It sits beside the encryption key generator and feeds the decryption datapath, which consumes round keys in reverse order.

## Interface
- No parameters (AES-128 only; 10 rounds fixed).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load `key_in` and begin expansion; sampled only in IDLE.
- key_in  in  [0:127]  cipher key, FIPS-197 byte order (bit 0 = MSB of byte 0).
- key_out  out  [0:127]  current round key (registered).
- round_out  out  [0:3]  round index of `key_out` (10 down to 0).
- key_valid  out  1  `key_out`/`round_out` hold a valid round key.
- key_ready  in  1  consumer accepts `key_out` when high with `key_valid`.
- key_last  out  1  high with `key_valid` when `round_out`==0.
- busy  out  1  high in EXPAND and EMIT.

## Operation
- Internal state: 128-bit key register K (words k0..k3), 4-bit round counter R, FSM {IDLE, EXPAND, EMIT}.
- Reset values:
  - FSM=IDLE, K=0, R=0.
  - key_valid=0, key_last=0, busy=0, key_out=0, round_out=0.
- rcon(r) uses the standard table: 1..10 → 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word. Any other index gives 0.
- T(w) = SubWord(RotWord(w)). Implement it with four instances of the existing `sbox` byte module.
  - The sbox input is muxed: forward uses k3; inverse uses k3^k2.
  - There is one sbox bank; forward and inverse never run in the same cycle.
- **IDLE:**
  - start=1: K<=key_in, R<=0, go to EXPAND.
  - start=0: hold.
- **EXPAND:** each cycle computes the forward step with r=R+1:
  - n0=k0^T(k3)^rcon(r), n1=n0^k1, n2=n1^k2, n3=n2^k3.
  - K<=n, R<=r.
  - When r==10, go to EMIT in the same edge.
- **EMIT:** key_out=K, round_out=R, key_valid=1, key_last=(R==0).
  - Handshake occurs on key_valid&key_ready at a rising edge.
  - On handshake with R>0, the inverse step with r=R:
    - p3=k3^k2, p2=k2^k1, p1=k1^k0, p0=k0^T(p3)^rcon(r).
    - K<=p, R<=R-1; stay in EMIT.
  - On handshake with R==0: go to IDLE; key_valid drops next cycle. K and round_out hold their last values.
  - Without handshake: K, R and key_valid hold stable (no combinational change of key_out).
- start is ignored while busy; there is no restart mid-schedule.
- rst at any cycle, including mid-EXPAND or mid-EMIT, forces all reset values at that edge. A start on the same edge as rst is ignored.
- key_ready is don't-care outside EMIT.

## Timing
- start sampled at edge E0, then EXPAND occupies edges E1..E10.
- key_valid rises after E10: round-10 key is visible 10 cycles after the start edge.
- busy rises after E0 and falls the edge after the round-0 handshake.
- With key_ready held high in EMIT, one key is delivered per cycle: 11 consecutive cycles, rounds 10→0.
- Total start-to-IDLE is 21 cycles with continuous ready.
- A back-to-back start is accepted on the first cycle the block is in IDLE again, i.e. the cycle after key_valid falls.
- key_last is asserted exactly in the cycle where round_out==0 and key_valid==1.
- Critical path per cycle: one sbox bank, plus the XOR chain, plus the register mux.

## Test plan
- **Reset:** assert rst for 2 cycles → all outputs 0, busy=0; key_ready toggling has no effect.
- **FIPS-197 schedule:** key_in=2b7e151628aed2a6abf7158809cf4f3c with a 1-cycle start, key_ready=1.
  - After 10 cycles key_valid=1, round_out=10, key_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = key_in with key_last=1.
  - key_valid low on the following cycle.
- **Backpressure:** same key, key_ready low for 5 cycles at round 10, then random.
  - key_out is stable while stalled.
  - Each round is delivered exactly once, in order 10..0.
  - Values match the forward schedule from a reference model.
- **Ignored start:** pulse start with a different key during EXPAND and during EMIT → output sequence unchanged.
- **Reset mid-operation:** assert rst at cycle 5 of EXPAND and again at round 6 of EMIT.
  - Block returns to IDLE with all outputs 0.
  - A new start then produces the correct full sequence.
- **Random keys:** 1000 random keys with random key_ready.
  - Every emitted key matches the forward-expansion model.
  - Round 0 always equals key_in.

Source files
------------

// File: rtl/aes_inv_keygen_if.sv
// rtl/aes_inv_keygen_if.sv - handshake bundle between the decryption key scheduler and its consumer
interface aes_inv_keygen_if;
    logic         start;
    logic [0:127] key_in;
    logic [0:127] key_out;
    logic [0:3]   round_out;
    logic         key_valid;
    logic         key_ready;
    logic         key_last;
    logic         busy;

    modport master (
        output start, key_in, key_ready,
        input  key_out, round_out, key_valid, key_last, busy
    );

    modport slave (
        input  start, key_in, key_ready,
        output key_out, round_out, key_valid, key_last, busy
    );
endinterface

// File: rtl/aes_inv_keygen.sv
// rtl/aes_inv_keygen.sv - AES-128 round-key scheduler emitting round keys 10 down to 0
// One shared S-box bank serves both the forward expansion and the backward walk.

module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as required
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_inv_keygen (
    input  logic            clk,
    input  logic            rst,
    aes_inv_keygen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_EMIT} state_t;

    state_t       r_state;
    logic [0:127] r_key;
    logic [0:3]   r_round;
    logic         r_valid;
    logic         r_last;
    logic         r_busy;

    logic [0:31]  w_k0, w_k1, w_k2, w_k3;
    logic [0:31]  w_sub_src;
    logic [0:31]  w_rot;
    logic [0:31]  w_sub;
    logic [0:3]   w_rnd;
    logic [0:31]  w_rcon;
    logic [0:127] w_fwd;
    logic [0:127] w_inv;
    logic         w_hs;

    function automatic logic [7:0] rcon(input logic [0:3] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w_k0 = r_key[0:31];
    assign w_k1 = r_key[32:63];
    assign w_k2 = r_key[64:95];
    assign w_k3 = r_key[96:127];

    // Backward step recovers the old k3 as k3^k2 before it goes through T()
    assign w_sub_src = (r_state == S_EMIT) ? (w_k3 ^ w_k2) : w_k3;
    assign w_rot     = {w_sub_src[8:31], w_sub_src[0:7]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            sbox u_sbox (
                .i_byte(w_rot[8*g +: 8]),
                .o_byte(w_sub[8*g +: 8])
            );
        end
    endgenerate

    assign w_rnd  = (r_state == S_EMIT) ? r_round : r_round + 4'd1;
    assign w_rcon = {rcon(w_rnd), 24'h000000};

    always_comb begin
        w_fwd[0:31]   = w_k0 ^ w_sub ^ w_rcon;
        w_fwd[32:63]  = w_fwd[0:31] ^ w_k1;
        w_fwd[64:95]  = w_fwd[32:63] ^ w_k2;
        w_fwd[96:127] = w_fwd[64:95] ^ w_k3;
    end

    always_comb begin
        w_inv[96:127] = w_k3 ^ w_k2;
        w_inv[64:95]  = w_k2 ^ w_k1;
        w_inv[32:63]  = w_k1 ^ w_k0;
        w_inv[0:31]   = w_k0 ^ w_sub ^ w_rcon;
    end

    assign w_hs = r_valid && bus.key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_key   <= bus.key_in;
                        r_round <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    r_key   <= w_fwd;
                    r_round <= w_rnd;
                    if (w_rnd == 4'd10) begin
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_hs) begin
                        if (r_round != 4'd0) begin
                            r_key   <= w_inv;
                            r_round <= r_round - 4'd1;
                            r_last  <= (r_round == 4'd1);
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.key_out   = r_key;
    assign bus.round_out = r_round;
    assign bus.key_valid = r_valid;
    assign bus.key_last  = r_last;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_aes_inv_keygen.sv
// tb/tb_aes_inv_keygen.sv - randomized bench against a FIPS-197 key-expansion model
module tb_aes_inv_keygen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_inv_keygen_if bus();

    aes_inv_keygen dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sb     [0:255];
    logic [7:0]   rc_tab [0:10];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc_tab[0] = 8'h00;
        rc_tab[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rc_tab[i] = gmul(rc_tab[i-1], 8'h02);
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
    endfunction

    task automatic expand_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_rot(t) ^ {rc_tab[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a negedge; mode 0 = ready high, 1 = random ready, 2 = stall 5 then random
    task automatic drive_schedule(input logic [127:0] key, input int mode, input int inj_expand, input int inj_emit);
        int waited;
        int exp_round;
        int cyc;
        bit done;
        bit stalled;
        logic [127:0] prev_key;
        logic [3:0] prev_round;
        expand_model(key);
        bus.key_in    = key;
        bus.start     = 1'b1;
        bus.key_ready = (mode == 0);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = rand128();
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
        waited = 0;
        while (!bus.key_valid && waited < 40) begin
            bus.start  = (waited == inj_expand);
            bus.key_in = rand128();
            @(negedge clk);
            waited++;
        end
        bus.start = 1'b0;
        n_tests++;
        if (waited != 10) begin
            n_fail++;
            $display("FAIL valid_latency: got %0d cycles want 10", waited);
        end
        exp_round = 10;
        cyc = 0;
        done = 1'b0;
        stalled = 1'b0;
        prev_key = '0;
        prev_round = '0;
        while (!done && cyc < 300) begin
            case (mode)
                0:       bus.key_ready = 1'b1;
                1:       bus.key_ready = 1'($urandom_range(0, 1));
                default: bus.key_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
            bus.start  = (cyc == inj_emit);
            bus.key_in = rand128();
            if (stalled) begin
                n_tests++;
                if (bus.key_out !== prev_key || bus.round_out !== prev_round) begin
                    n_fail++;
                    $display("FAIL stall_stable: got r%0d %h want r%0d %h", bus.round_out, bus.key_out, prev_round, prev_key);
                end
            end
            n_tests++;
            if (bus.key_valid !== 1'b1 || bus.round_out !== 4'(exp_round)) begin
                n_fail++;
                $display("FAIL emit_round: got valid=%b round=%0d want valid=1 round=%0d", bus.key_valid, bus.round_out, exp_round);
            end
            n_tests++;
            if (bus.key_out !== exp_rk[exp_round]) begin
                n_fail++;
                $display("FAIL emit_key r%0d: got %h want %h", exp_round, bus.key_out, exp_rk[exp_round]);
            end
            n_tests++;
            if (bus.key_last !== (exp_round == 0)) begin
                n_fail++;
                $display("FAIL key_last r%0d: got %b want %b", exp_round, bus.key_last, (exp_round == 0));
            end
            got_rk[exp_round] = bus.key_out;
            prev_key   = bus.key_out;
            prev_round = bus.round_out;
            stalled    = !bus.key_ready;
            if (bus.key_ready) begin
                if (exp_round == 0) done = 1'b1;
                else exp_round--;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL emit_timeout: stuck at round %0d want 0", exp_round);
        end
        n_tests++;
        if (bus.key_valid !== 1'b0 || bus.busy !== 1'b0 || bus.key_last !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: got valid=%b busy=%b last=%b want 0 0 0", bus.key_valid, bus.busy, bus.key_last);
        end
        n_tests++;
        if (bus.key_out !== key || bus.round_out !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_after_done: got r%0d %h want r0 %h", bus.round_out, bus.key_out, key);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.key_in = rand128();
        for (int i = 0; i < 2; i++) begin
            bus.key_ready = ~bus.key_ready;
            @(negedge clk);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        n_tests++;
        if (bus.key_out !== 128'h0 || bus.round_out !== 4'd0 || bus.key_valid !== 1'b0
            || bus.key_last !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got key=%h r=%0d v=%b l=%b b=%b want all 0",
                     bus.key_out, bus.round_out, bus.key_valid, bus.key_last, bus.busy);
        end
        bus.key_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: got busy=%b valid=%b want 0 0", bus.busy, bus.key_valid);
        end
    endtask

    task automatic test_fips();
        drive_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, -1, -1);
        n_tests++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL fips_r10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        n_tests++;
        if (got_rk[9] !== 128'hac7766f319fadc2128d12941575c006e) begin
            n_fail++;
            $display("FAIL fips_r9: got %h want ac7766f319fadc2128d12941575c006e", got_rk[9]);
        end
        n_tests++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_fail++;
            $display("FAIL fips_r1: got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        n_tests++;
        if (got_rk[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            n_fail++;
            $display("FAIL fips_r0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", got_rk[0]);
        end
    endtask

    task automatic test_backpressure();
        drive_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 2, -1, -1);
    endtask

    task automatic test_ignored_start();
        drive_schedule(rand128(), 1, 3, 4);
        drive_schedule(rand128(), 0, 7, 2);
    endtask

    task automatic test_reset_mid();
        int guard;
        bus.key_in = rand128();
        bus.start = 1'b1;
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus.key_out !== 128'h0 || bus.round_out !== 4'd0 || bus.key_valid !== 1'b0
            || bus.key_last !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_expand: got key=%h r=%0d v=%b l=%b b=%b want all 0",
                     bus.key_out, bus.round_out, bus.key_valid, bus.key_last, bus.busy);
        end
        bus.key_in = rand128();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!(bus.key_valid && bus.round_out == 4'd6) && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 60) begin
            n_fail++;
            $display("FAIL reach_round6: got round=%0d want 6", bus.round_out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (bus.key_out !== 128'h0 || bus.round_out !== 4'd0 || bus.key_valid !== 1'b0
            || bus.key_last !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_emit: got key=%h r=%0d v=%b l=%b b=%b want all 0",
                     bus.key_out, bus.round_out, bus.key_valid, bus.key_last, bus.busy);
        end
        drive_schedule(rand128(), 1, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) drive_schedule(rand128(), 0, -1, -1);
    endtask

    task automatic test_random_keys();
        for (int i = 0; i < 1000; i++) drive_schedule(rand128(), 1, -1, -1);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.key_in = '0;
        bus.key_ready = 1'b0;
        build_tables();
        @(negedge clk);
        test_reset();
        test_fips();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random_keys();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
